// File: rtl/stft_v1_path_trunc_pkg.sv
// Shared types for the streaming path-truncation block.
//   mode_e  : substring selection (prefix before first delimiter, directory, basename)
//   state_e : controller states (LOAD collects a string, EMIT streams the result)
//   len_w   : width needed to hold a length in the range 0..max_len inclusive
package stft_v1_path_trunc_pkg;

    typedef enum logic [1:0] {
        MODE_FIRST = 2'd0,
        MODE_DIR   = 2'd1,
        MODE_BASE  = 2'd2
    } mode_e;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/stft_v1_char_buf.sv
// Character store for one path string.
//   clk   : clock
//   we    : write enable, writes wdata at waddr on the rising edge
//   waddr : write address
//   wdata : character to store
//   raddr : read address (asynchronous read)
//   rdata : character at raddr
// The array carries no reset: only locations below the write count are ever read.
module stft_v1_char_buf
    import stft_v1_path_trunc_pkg::*;
#(
    parameter int CHAR_W  = 8,
    parameter int MAX_LEN = 512,
    localparam int AW     = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [CHAR_W-1:0] rdata
);

    logic [CHAR_W-1:0] mem_r [MAX_LEN];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/stft_v1_path_trunc_stream.sv
// Streaming path sanitiser: buffers one path string from a valid/ready stream,
// then emits the selected substring (prefix / directory / basename), optionally
// zero-padded to MAX_LEN beats.
//   clk, areset                       : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last : character input stream
//   out_valid/out_ready/out_data/out_last : character output stream
//   out_len : substring length without padding, stable for the whole string
//   out_ovf : input exceeded MAX_LEN characters, stable for the whole string
module stft_v1_path_trunc_stream
    import stft_v1_path_trunc_pkg::*;
#(
    parameter int                CHAR_W  = 8,
    parameter int                MAX_LEN = 512,
    parameter logic [CHAR_W-1:0] DELIM   = CHAR_W'(8'h2F),
    parameter mode_e             MODE    = MODE_FIRST,
    parameter bit                PAD     = 1'b0,
    localparam int               LEN_W   = len_w(MAX_LEN)
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAR_W-1:0] out_data,
    output logic              out_last,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_ovf
);

    localparam int              AW        = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    state_e state_r, state_nxt_s;

    logic [LEN_W-1:0] wr_cnt_r, first_idx_r, last_idx_r;
    logic             found_r, ovf_r;
    logic [LEN_W-1:0] start_r, sub_len_r, total_r, beat_r;

    logic              in_ready_r, out_valid_r, out_last_r, out_ovf_r;
    logic [CHAR_W-1:0] out_data_r;
    logic [LEN_W-1:0]  out_len_r;

    logic             accept_s, oaccept_s, stored_s, is_delim_s;
    logic             found_s, ovf_s;
    logic [LEN_W-1:0] first_s, last_s, len_s;
    logic [LEN_W-1:0] start_s, end_s, sub_len_s, total_s;
    logic [LEN_W-1:0] nb_s, emit_addr_s, addr_sel_s;
    logic [AW-1:0]    raddr_s;
    logic [CHAR_W-1:0] rdata_s;

    assign accept_s  = in_valid && in_ready_r && (state_r == ST_LOAD);
    assign oaccept_s = out_valid_r && out_ready;
    assign stored_s  = accept_s && (wr_cnt_r < MAX_LEN_L);
    assign is_delim_s = stored_s && (in_data == DELIM);

    // Delimiter tracking including the beat being accepted this cycle, so the
    // in_last character participates in the range calculation.
    always_comb begin
        found_s = found_r || is_delim_s;
        if (found_r) begin
            first_s = first_idx_r;
        end else if (is_delim_s) begin
            first_s = wr_cnt_r;
        end else begin
            first_s = MAX_LEN_L;
        end
        if (is_delim_s) begin
            last_s = wr_cnt_r;
        end else begin
            last_s = last_idx_r;
        end
        len_s = wr_cnt_r + LEN_W'(stored_s);
        ovf_s = ovf_r || (accept_s && !stored_s);
    end

    // Substring range [start, end) and the number of beats the string occupies.
    always_comb begin
        start_s = '0;
        end_s   = '0;
        case (MODE)
            MODE_FIRST: begin
                start_s = '0;
                end_s   = found_s ? first_s : len_s;
            end
            MODE_DIR: begin
                start_s = '0;
                end_s   = found_s ? (last_s + ONE_L) : '0;
            end
            MODE_BASE: begin
                start_s = found_s ? (last_s + ONE_L) : '0;
                end_s   = len_s;
            end
            default: begin
                start_s = '0;
                end_s   = len_s;
            end
        endcase
        sub_len_s = end_s - start_s;
        if (PAD) begin
            total_s = MAX_LEN_L;
        end else if (sub_len_s == '0) begin
            total_s = ONE_L;
        end else begin
            total_s = sub_len_s;
        end
    end

    // Read address: first result character while loading, next one while emitting.
    always_comb begin
        nb_s        = beat_r + ONE_L;
        emit_addr_s = start_r + nb_s;
        if (state_r == ST_LOAD) begin
            addr_sel_s = start_s;
        end else begin
            addr_sel_s = emit_addr_s;
        end
    end

    assign raddr_s = AW'(addr_sel_s);

    stft_v1_char_buf #(
        .CHAR_W  (CHAR_W),
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clk   (clk),
        .we    (stored_s),
        .waddr (AW'(wr_cnt_r)),
        .wdata (in_data),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && in_last) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_EMIT: begin
                if (oaccept_s && out_last_r) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: state_nxt_s = ST_LOAD;
        endcase
    end

    // Tracking counters and registered output stream.
    always_ff @(posedge clk) begin
        if (areset) begin
            wr_cnt_r    <= '0;
            first_idx_r <= '0;
            last_idx_r  <= '0;
            found_r     <= 1'b0;
            ovf_r       <= 1'b0;
            start_r     <= '0;
            sub_len_r   <= '0;
            total_r     <= '0;
            beat_r      <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_len_r   <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            in_ready_r <= (state_nxt_s == ST_LOAD);
            if (state_r == ST_LOAD) begin
                if (accept_s) begin
                    wr_cnt_r    <= len_s;
                    found_r     <= found_s;
                    first_idx_r <= first_s;
                    last_idx_r  <= last_s;
                    ovf_r       <= ovf_s;
                    if (in_last) begin
                        start_r     <= start_s;
                        sub_len_r   <= sub_len_s;
                        total_r     <= total_s;
                        beat_r      <= '0;
                        out_valid_r <= 1'b1;
                        out_len_r   <= sub_len_s;
                        out_ovf_r   <= ovf_s;
                        out_last_r  <= (total_s == ONE_L);
                        // The in_last character is written this very edge, so
                        // when it is the first result character take it directly.
                        if (sub_len_s == '0) begin
                            out_data_r <= '0;
                        end else if (start_s == wr_cnt_r) begin
                            out_data_r <= in_data;
                        end else begin
                            out_data_r <= rdata_s;
                        end
                    end
                end
            end else if (oaccept_s) begin
                if (out_last_r) begin
                    wr_cnt_r    <= '0;
                    first_idx_r <= '0;
                    last_idx_r  <= '0;
                    found_r     <= 1'b0;
                    ovf_r       <= 1'b0;
                    beat_r      <= '0;
                    out_valid_r <= 1'b0;
                    out_data_r  <= '0;
                    out_last_r  <= 1'b0;
                    out_len_r   <= '0;
                    out_ovf_r   <= 1'b0;
                end else begin
                    beat_r     <= nb_s;
                    out_data_r <= (nb_s < sub_len_r) ? rdata_s : '0;
                    out_last_r <= (nb_s == (total_r - ONE_L));
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_len   = out_len_r;
    assign out_ovf   = out_ovf_r;

endmodule
